// File: rtl/mem_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_ctrl_if
// Summary  : Command, write-stream, read-stream and memory-port bundle for
//            the burst controller.
// Revision : 1.0
// ============================================================================
interface mem_burst_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 5,
    parameter int LEN_W  = ADDR_W + 1
);
    // Burst command
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    // Write word stream
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    // Read word stream
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    // Status
    logic              busy;
    logic              done;

    // Memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic              mem_o_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  mem_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
        output mem_addr, mem_rw, mem_o_en, mem_wdata
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        output mem_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
        input  mem_addr, mem_rw, mem_o_en, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_ctrl
// Summary  : Turns burst commands into single-word accesses on the message
//            memory port, with a 4-entry credit-managed read buffer.
// Revision : 1.0
// ============================================================================
module mem_burst_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 5,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_burst_ctrl_if.master bus
);
    localparam int c_BUF_DEPTH = 4;
    localparam int c_PTR_W     = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_cur;
    logic [LEN_W-1:0]    r_rem;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_rw;
    logic                r_mem_o_en;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_rd_pipe;
    logic                r_done;

    logic [DATA_W-1:0]   r_buf [c_BUF_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_PTR_W:0]    r_count;

    logic                w_cmd_ready;
    logic                w_wr_ready;
    logic                w_issue;
    logic                w_accept;
    logic                w_wr_hs;
    logic                w_last;
    logic                w_credit;
    logic                w_push;
    logic                w_pop;
    logic [c_PTR_W:0]    w_inflight;

    // A read stays in flight from the edge that registers it until the edge
    // that captures the memory's registered data two cycles later.
    assign w_inflight = {{c_PTR_W{1'b0}}, r_mem_o_en} + {{c_PTR_W{1'b0}}, r_rd_pipe};
    assign w_credit   = (r_count + w_inflight) < (c_PTR_W+1)'(c_BUF_DEPTH);
    assign w_last     = (r_rem == LEN_W'(1));
    assign w_accept   = w_cmd_ready & bus.cmd_valid;
    assign w_wr_hs    = w_wr_ready & bus.wr_valid;
    assign w_push     = r_rd_pipe;
    assign w_pop      = (r_count != '0) & bus.rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cmd_ready  = 1'b0;
        w_wr_ready   = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0) begin
                        w_state_next = S_DONE;
                    end else if (bus.cmd_rw) begin
                        w_state_next = S_WR;
                    end else begin
                        w_state_next = S_RD;
                    end
                end
            end
            S_WR: begin
                w_wr_ready = 1'b1;
                if (bus.wr_valid && w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_RD: begin
                w_issue = w_credit;
                if (w_credit && w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A write registered last cycle is only sampled by the memory now.
                if ((w_inflight == '0) && (r_count == '0) && !r_mem_rw) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur       <= '0;
            r_rem       <= '0;
            r_mem_addr  <= '0;
            r_mem_rw    <= 1'b0;
            r_mem_o_en  <= 1'b0;
            r_mem_wdata <= '0;
            r_rd_pipe   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mem_rw   <= 1'b0;
            r_mem_o_en <= 1'b0;
            r_rd_pipe  <= r_mem_o_en;
            r_done     <= (r_state == S_DONE);
            if (w_accept) begin
                r_cur <= bus.cmd_addr;
                r_rem <= bus.cmd_len;
            end
            if (w_wr_hs) begin
                r_mem_rw    <= 1'b1;
                r_mem_addr  <= r_cur;
                r_mem_wdata <= bus.wr_data;
                r_cur       <= r_cur + ADDR_W'(1);
                r_rem       <= r_rem - LEN_W'(1);
            end
            if (w_issue) begin
                r_mem_o_en <= 1'b1;
                r_mem_addr <= r_cur;
                r_cur      <= r_cur + ADDR_W'(1);
                r_rem      <= r_rem - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= '{default: '0};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_buf[r_wptr] <= bus.mem_rdata;
                r_wptr        <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.wr_ready  = w_wr_ready;
    assign bus.rd_valid  = (r_count != '0);
    assign bus.rd_data   = r_buf[r_rptr];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_o_en  = r_mem_o_en;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_burst_ctrl
// Summary  : Directed and random bursts against a shadow-memory reference.
// Revision : 1.0
// ============================================================================
module tb_mem_burst_ctrl;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 5;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    mem_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory with posedge-sampled inputs and registered read data
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] mem_q = '0;
    always @(posedge clk) begin
        if (bus.mem_rw)        mem[bus.mem_addr] <= bus.mem_wdata;
        else if (bus.mem_o_en) mem_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = mem_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle observation of port activity
    logic [ADDR_W+DATA_W-1:0] wlog[$];
    int                       wcyc[$];
    logic [ADDR_W-1:0]        rlog[$];
    logic [DATA_W-1:0]        pops[$];
    int                       pcyc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int first_rv = -1;
    always @(negedge clk) begin
        if (bus.mem_rw) begin
            wlog.push_back({bus.mem_addr, bus.mem_wdata});
            wcyc.push_back(cyc);
        end
        if (bus.mem_o_en) rlog.push_back(bus.mem_addr);
        if (bus.rd_valid && bus.rd_ready) begin
            pops.push_back(bus.rd_data);
            pcyc.push_back(cyc);
        end
        if (bus.rd_valid && first_rv < 0) first_rv = cyc;
        if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] wq[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reset_vec();
        return {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done,
                bus.mem_rw, bus.mem_o_en, bus.mem_addr, bus.mem_wdata, bus.rd_data};
    endfunction

    localparam logic [31:0] RESET_EXP = 32'(1) << (7 + ADDR_W + 2 * DATA_W - 1);

    task automatic clear_logs();
        wlog = {}; wcyc = {}; rlog = {}; pops = {}; pcyc = {};
        done_cnt = 0;
        first_rv = -1;
    endtask

    // wr_mode: 0 = wr_valid held, 1 = random gaps
    // rdy_mode: 0 = rd_ready held, 1 = random, 2 = low for 6 cycles then high
    task automatic run_burst(input string tag, input logic rw, input int addr, input int len,
                             input int wr_mode, input int rdy_mode, input bit poke);
        logic [DATA_W-1:0] exp_d[$];
        int guard;
        int acc_cyc;
        bit hs;
        if (rw) begin
            while (wq.size() < len) wq.push_back(DATA_W'($urandom));
        end
        for (int i = 0; i < len; i++) begin
            if (rw) exp_d.push_back(wq[i]);
            else    exp_d.push_back(ref_mem[(addr + i) % DEPTH]);
        end
        clear_logs();
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = ADDR_W'(addr);
        bus.cmd_len   = LEN_W'(len);
        tick();
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
        check({tag, "_busy_after_accept"}, {31'd0, bus.busy}, 32'd1);

        guard = 0;
        while (done_cnt == 0 && guard < 400) begin
            bus.cmd_valid = 1'b0;
            if (poke && guard == 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_rw    = ~rw;
                bus.cmd_addr  = ADDR_W'(addr + 3);
                bus.cmd_len   = LEN_W'(5);
                check({tag, "_ready_while_busy"}, 32'(bus.cmd_ready), 32'd0);
            end
            if (rw) begin
                bus.wr_valid = (wq.size() > 0) && (wr_mode == 0 || $urandom_range(0, 3) != 0);
                bus.wr_data  = (wq.size() > 0) ? wq[0] : '0;
                hs = bus.wr_valid && bus.wr_ready;
            end else begin
                hs = 1'b0;
            end
            case (rdy_mode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = ($urandom_range(0, 2) != 0);
                default: bus.rd_ready = (guard >= 6);
            endcase
            if (rdy_mode == 2 && (guard == 4 || guard == 6)) begin
                check($sformatf("%s_stall_valid_g%0d", tag, guard), 32'(bus.rd_valid), 32'd1);
                check($sformatf("%s_stall_data_g%0d", tag, guard), 32'(bus.rd_data), 32'(exp_d[0]));
            end
            if (rdy_mode == 2 && guard == 6) begin
                check({tag, "_stall_issues"}, rlog.size(), 32'd4);
                check({tag, "_stall_pops"}, pops.size(), 32'd0);
            end
            tick();
            if (hs) void'(wq.pop_front());
            guard++;
        end
        bus.wr_valid  = 1'b0;
        bus.rd_ready  = 1'b0;
        bus.cmd_valid = 1'b0;
        check({tag, "_done_seen"}, done_cnt, 32'd1);
        repeat (3) tick();
        check({tag, "_single_done"}, done_cnt, 32'd1);
        check({tag, "_idle_after"}, {30'd0, bus.busy, bus.cmd_ready}, 32'd1);

        if (rw) begin
            check({tag, "_wr_count"}, wlog.size(), len);
            for (int i = 0; i < len; i++) begin
                check($sformatf("%s_wr%0d", tag, i),
                      (i < wlog.size()) ? 32'(wlog[i]) : 32'hxxxx_xxxx,
                      (((addr + i) % DEPTH) << DATA_W) | 32'(exp_d[i]));
                ref_mem[(addr + i) % DEPTH] = exp_d[i];
            end
            for (int i = 0; i < len; i++) begin
                check($sformatf("%s_mem%0d", tag, i),
                      32'(mem[(addr + i) % DEPTH]), 32'(ref_mem[(addr + i) % DEPTH]));
            end
            if (wr_mode == 0 && len > 1 && wcyc.size() == len)
                check({tag, "_wr_back_to_back"}, wcyc[len-1] - wcyc[0], len - 1);
            check({tag, "_no_reads"}, rlog.size(), 32'd0);
        end else begin
            check({tag, "_rd_count"}, pops.size(), len);
            check({tag, "_issue_count"}, rlog.size(), len);
            for (int i = 0; i < len; i++) begin
                check($sformatf("%s_rd%0d", tag, i),
                      (i < pops.size()) ? 32'(pops[i]) : 32'hxxxx_xxxx, 32'(exp_d[i]));
                check($sformatf("%s_ra%0d", tag, i),
                      (i < rlog.size()) ? 32'(rlog[i]) : 32'hxxxx_xxxx, (addr + i) % DEPTH);
            end
            if (rdy_mode == 0 && len > 0) begin
                check({tag, "_first_latency"}, first_rv - acc_cyc, 32'd3);
                if (pcyc.size() == len)
                    check({tag, "_rd_back_to_back"}, pcyc[len-1] - pcyc[0], len - 1);
            end
            check({tag, "_no_writes"}, wlog.size(), 32'd0);
        end
        // Done relative to the cycle in which the command handshake was presented
        if (len == 0) check({tag, "_zero_done_time"}, done_cyc - (acc_cyc - 1), 32'd2);
        wq = {};
    endtask

    logic r_rw;
    int   r_addr;
    int   r_len;
    int   n_iss;
    int   guard;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs", reset_vec(), RESET_EXP);
        rst = 1'b0;
        tick();

        wq = '{5'h01, 5'h02, 5'h03, 5'h04};
        run_burst("t1_write", 1'b1, 2, 4, 0, 0, 1'b0);
        run_burst("t2_read", 1'b0, 2, 4, 0, 0, 1'b0);

        wq = '{5'h0A, 5'h0B, 5'h0C, 5'h0D};
        run_burst("t3_wrap_write", 1'b1, 6, 4, 0, 0, 1'b0);
        run_burst("t3_wrap_read", 1'b0, 6, 4, 0, 0, 1'b0);

        run_burst("t4_fill", 1'b1, 0, 8, 0, 0, 1'b0);
        run_burst("t4_backpressure", 1'b0, 3, 8, 0, 2, 1'b0);

        run_burst("t5_zero_rd", 1'b0, 5, 0, 0, 0, 1'b0);
        run_burst("t5_zero_wr", 1'b1, 1, 0, 0, 0, 1'b0);
        run_burst("t5_poke", 1'b1, 1, 3, 0, 0, 1'b1);

        // Reset after exactly two read issues
        clear_logs();
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = ADDR_W'(0);
        bus.cmd_len   = LEN_W'(8);
        tick();
        bus.cmd_valid = 1'b0;
        n_iss = 0;
        guard = 0;
        while (n_iss < 2 && guard < 20) begin
            tick();
            if (bus.mem_o_en) n_iss++;
            guard++;
        end
        check("t6_two_issues", n_iss, 32'd2);
        rst = 1'b1;
        tick();
        check("t6_reset_outputs", reset_vec(), RESET_EXP);
        rst = 1'b0;
        repeat (6) tick();
        check("t6_no_done", done_cnt, 32'd0);
        check("t6_rd_valid_low", 32'(bus.rd_valid), 32'd0);
        run_burst("t6_write2", 1'b1, 4, 2, 0, 0, 1'b0);
        run_burst("t6_read2", 1'b0, 4, 2, 0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            r_rw   = 1'($urandom_range(0, 1));
            r_addr = $urandom_range(0, DEPTH - 1);
            r_len  = $urandom_range(0, DEPTH);
            run_burst($sformatf("rnd%0d", n), r_rw, r_addr, r_len, 1, 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
